alu_cmd_driver: RTL and testbench
=================================

Name: alu_cmd_driver

Overview:
Upstream feeder stage for the ALU. Buffers operand/op_code commands from a producer in a small FIFO and drives them onto the ALU's src_a/src_b/op_code inputs from registers. Captures the combinational result/z_flag into a response register with a valid/ready handshake. This forms a 2-stage pipeline that sustains one operation per cycle when the consumer is ready.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
DATA_W, 32, operand/result width
OP_W, 3, op_code width

Ports:
clock  input  1  single clock, rising edge
reset_n  input  1  synchronous, active-low reset
cmd_valid  input  1  producer command valid
cmd_ready  output  1  FIFO can accept (= !full)
cmd_src_a  input  DATA_W  operand A
cmd_src_b  input  DATA_W  operand B
cmd_op_code  input  OP_W  operation
src_a  output  DATA_W  registered operand A to ALU
src_b  output  DATA_W  registered operand B to ALU
op_code  output  OP_W  registered op_code to ALU
result  input  DATA_W  ALU result (combinational from src_a/src_b/op_code)
z_flag  input  1  ALU zero flag
rsp_valid  output  1  response valid
rsp_ready  input  1  consumer ready
rsp_result  output  DATA_W  captured result
rsp_z_flag  output  1  captured z_flag
rsp_op_code  output  OP_W  op_code of captured op
busy  output  1  FIFO non-empty OR exec_valid OR rsp_valid

Behaviour:
- Clock and reset: one clock, clock; reset is synchronous and active-low (reset_n sampled on rising edge of clock).
- Reset values: all outputs 0, except cmd_ready=1. FIFO empty, exec_valid=0.
- Accept: the command is written when cmd_valid && cmd_ready. cmd_ready depends only on FIFO count (no combinational path from rsp_ready).
- Exec stage (exec_valid bit = state IDLE/EXEC):
  - capture = exec_valid && (!rsp_valid || rsp_ready)
  - pop = !empty && (!exec_valid || capture)
  - On pop, the FIFO head loads src_a/src_b/op_code and exec_valid<=1.
  - On capture without pop, exec_valid<=0.
  - When exec_valid && !capture (STALL), operand registers hold, so the ALU output stays stable.
  - In IDLE, operand registers keep their last values.
- Response: on capture, rsp_result<=result, rsp_z_flag<=z_flag, rsp_op_code<=op_code, rsp_valid<=1.
  - rsp_valid && rsp_ready && !capture -> rsp_valid<=0.
  - While rsp_valid && !rsp_ready, all rsp_* are held stable.
- Latency: command accepted at edge E0 -> operands driven after E1 -> rsp_valid after E2 (2 cycles). Throughput is 1 op/cycle with rsp_ready=1 and no bubbles.
- Ordering: strictly FIFO; no reordering or dropping.
- Full: simultaneous push and pop while full is not possible because cmd_ready=0. Push+pop while non-full keeps count unchanged.
- Empty with exec_valid: capture occurs, then the block returns to IDLE.
- Pointer wrap: modulo DEPTH; count width is $clog2(DEPTH)+1.
- Reset mid-operation: FIFO contents, in-flight exec and pending response are all discarded. rsp_valid=0 on the cycle after reset is sampled.

Optional Feature:
ALU_DRV_STATS_EN: when defined, adds outputs ops_done[15:0] (increments on each capture) and zero_cnt[15:0] (increments on capture with z_flag=1). Both saturate at 16'hFFFF and reset to 0. When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package alu_pkg:
  - alu_op_t (logic [2:0]) with ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLL=6, SRL=7.
  - alu_cmd_t struct {src_a, src_b, op_code}.
  - DATA_W default constant.
- Sub-module: alu_cmd_fifo (parameterised sync FIFO of alu_cmd_t with push/pop/full/empty/count).

Test Plan:
- Single op: push {A=5,B=7,ADD} with rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_result=12, rsp_z_flag=0, rsp_op_code=0.
- Zero flag: push {A=9,B=9,SUB} -> rsp_result=0, rsp_z_flag=1.
- Back-pressure: rsp_ready=0, push 6 ops -> exactly 4 accepted plus 1 in exec plus 1 in rsp (cmd_ready=0 after the 6th accept). Exec operands and rsp_* stay stable. Raising rsp_ready delivers all 6 in order, one per cycle.
- Streaming: 16 back-to-back ops with cmd_valid=1 and rsp_ready=1 -> 16 responses on 16 consecutive cycles with no bubbles.
- Reset mid-flight: 3 ops queued, assert reset_n=0 for 1 cycle -> rsp_valid=0, cmd_ready=1, busy=0. No stale response after reset is released.
- ALU_DRV_STATS_EN: 3 ops, one producing zero -> ops_done=3, zero_cnt=1; saturation checked by preloading 16'hFFFE and running 3 ops -> 16'hFFFF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU types: op encodings, command bundle, drive-stage state.
// Included by alu_cmd_fifo and alu_cmd_driver.
package alu_pkg;

  localparam int ALU_DATA_W = 32;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4,
    SLT = 3'd5,
    SLL = 3'd6,
    SRL = 3'd7
  } alu_op_t;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] src_a;
    logic [ALU_DATA_W-1:0] src_b;
    alu_op_t               op_code;
  } alu_cmd_t;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } drv_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries (power of 2).
// Pointers wrap naturally; count is one bit wider than the pointers.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = alu_cmd_t,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  T              din,
  input  logic          pop,
  output T              dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// ALU feeder: command FIFO -> operand regs -> response reg.
// Optional ALU_DRV_STATS_EN adds ops_done / zero_cnt counters.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W   = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_src_a,
  input  logic [DATA_W-1:0] cmd_src_b,
  input  logic [OP_W-1:0]   cmd_op_code,
  output logic [DATA_W-1:0] src_a,
  output logic [DATA_W-1:0] src_b,
  output logic [OP_W-1:0]   op_code,
  input  logic [DATA_W-1:0] result,
  input  logic              z_flag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_z_flag,
  output logic [OP_W-1:0]   rsp_op_code,
`ifdef ALU_DRV_STATS_EN
  output logic [15:0]       ops_done,
  output logic [15:0]       zero_cnt,
`endif
  output logic              busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [OP_W-1:0]   op_code;
  } cmd_t;

  cmd_t          fifo_din;
  cmd_t          fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  drv_state_t state;
  drv_state_t state_nxt;
  logic       exec_valid;
  logic       push;
  logic       pop;
  logic       capture;

  assign fifo_din = '{src_a: cmd_src_a, src_b: cmd_src_b, op_code: cmd_op_code};

  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && cmd_ready;
  assign exec_valid = (state == EXEC);
  assign capture    = exec_valid && (!rsp_valid || rsp_ready);
  assign pop        = !fifo_empty && (!exec_valid || capture);
  assign busy       = (fifo_count != '0) || exec_valid || rsp_valid;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (cmd_t)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .din     (fifo_din),
    .pop     (pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (pop) state_nxt = EXEC;
      EXEC: if (capture && !pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands only move on pop, so a stalled op keeps the ALU output steady.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      src_a   <= '0;
      src_b   <= '0;
      op_code <= '0;
    end else if (pop) begin
      src_a   <= fifo_dout.src_a;
      src_b   <= fifo_dout.src_b;
      op_code <= fifo_dout.op_code;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_z_flag  <= 1'b0;
      rsp_op_code <= '0;
    end else if (capture) begin
      rsp_valid   <= 1'b1;
      rsp_result  <= result;
      rsp_z_flag  <= z_flag;
      rsp_op_code <= op_code;
    end else if (rsp_ready) begin
      rsp_valid   <= 1'b0;
    end
  end

`ifdef ALU_DRV_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ops_done <= '0;
      zero_cnt <= '0;
    end else if (capture) begin
      if (ops_done != 16'hFFFF) ops_done <= ops_done + 16'd1;
      if (z_flag && zero_cnt != 16'hFFFF) zero_cnt <= zero_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver with a behavioural ALU.
// Directed vector table plus back-pressure, streaming and reset sequences.
module tb_alu_cmd_driver;
  import alu_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_src_a;
  logic [31:0] cmd_src_b;
  logic [2:0]  cmd_op_code;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [2:0]  op_code;
  logic [31:0] result;
  logic        z_flag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_z_flag;
  logic [2:0]  rsp_op_code;
  logic        busy;
`ifdef ALU_DRV_STATS_EN
  logic [15:0] ops_done;
  logic [15:0] zero_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  alu_cmd_driver #(.DEPTH(4), .DATA_W(32), .OP_W(3)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_src_a   (cmd_src_a),
    .cmd_src_b   (cmd_src_b),
    .cmd_op_code (cmd_op_code),
    .src_a       (src_a),
    .src_b       (src_b),
    .op_code     (op_code),
    .result      (result),
    .z_flag      (z_flag),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_z_flag  (rsp_z_flag),
    .rsp_op_code (rsp_op_code),
`ifdef ALU_DRV_STATS_EN
    .ops_done    (ops_done),
    .zero_cnt    (zero_cnt),
`endif
    .busy        (busy)
  );

  function automatic logic [31:0] alu_f(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [2:0]  op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return {31'd0, $signed(a) < $signed(b)};
      3'd6: return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  assign result = alu_f(src_a, src_b, op_code);
  assign z_flag = (result == 32'd0);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] r;
    logic        z;
  } vec_t;

  vec_t vecs[10];

  task automatic run_vec(input vec_t v);
    int n;
    bit got;
    @(negedge clock);
    cmd_src_a   = v.a;
    cmd_src_b   = v.b;
    cmd_op_code = v.op;
    cmd_valid   = 1'b1;
    chk("vec_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    n = 0;
    got = 0;
    while (!got && n < 8) begin
      @(posedge clock);
      #1 n++;
      if (n == 1) chk("vec_src_a", src_a, v.a);
      if (rsp_valid) got = 1;
    end
    chk("vec_latency", 32'(n), 32'd2);
    chk("vec_result", rsp_result, v.r);
    chk("vec_z_flag", 32'(rsp_z_flag), 32'(v.z));
    chk("vec_op_code", 32'(rsp_op_code), 32'(v.op));
    @(posedge clock);
    #1 chk("vec_rsp_drain", 32'(rsp_valid), 32'd0);
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] bp_src_a;
  logic [31:0] bp_rsp;
  int          got_n;
  int          first_cyc;
  int          last_cyc;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'd5,        32'd7,        ADD, 32'd12,       1'b0};
    vecs[1] = '{32'd9,        32'd9,        SUB, 32'd0,        1'b1};
    vecs[2] = '{32'h0000F0F0, 32'h00000FF0, AND, 32'h000000F0, 1'b0};
    vecs[3] = '{32'h0000F000, 32'h0000000F, OR,  32'h0000F00F, 1'b0};
    vecs[4] = '{32'h000000FF, 32'h0000000F, XOR, 32'h000000F0, 1'b0};
    vecs[5] = '{32'd3,        32'd5,        SLT, 32'd1,        1'b0};
    vecs[6] = '{32'hFFFFFFFF, 32'd1,        SLT, 32'd1,        1'b0};
    vecs[7] = '{32'd1,        32'd4,        SLL, 32'd16,       1'b0};
    vecs[8] = '{32'h80000000, 32'd31,       SRL, 32'd1,        1'b0};
    vecs[9] = '{32'd5,        32'd5,        XOR, 32'd0,        1'b1};

    reset_n     = 1'b0;
    cmd_valid   = 1'b0;
    cmd_src_a   = '0;
    cmd_src_b   = '0;
    cmd_op_code = '0;
    rsp_ready   = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_src_a", src_a, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // back-pressure: 6 ops fill FIFO(4) + exec + rsp
    @(negedge clock);
    rsp_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      cmd_src_a   = 32'(i * 10 + 1);
      cmd_src_b   = 32'd2;
      cmd_op_code = ADD;
      cmd_valid   = 1'b1;
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd1);
      exp_q.push_back(32'(i * 10 + 3));
      @(posedge clock);
    end
    #1 cmd_valid = 1'b0;
    @(negedge clock);
    chk("bp_full", 32'(cmd_ready), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    bp_src_a = src_a;
    bp_rsp   = rsp_result;
    chk("bp_exec_op", src_a, 32'd11);
    chk("bp_rsp_op", rsp_result, 32'd3);
    repeat (3) @(negedge clock);
    chk("bp_hold_src", src_a, bp_src_a);
    chk("bp_hold_rsp", rsp_result, bp_rsp);
    chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    got_n = 0;
    first_cyc = -1;
    last_cyc = -1;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid) begin
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        if (exp_q.size() > 0) chk("bp_order", rsp_result, exp_q.pop_front());
        got_n++;
      end
      @(negedge clock);
    end
    chk("bp_count", 32'(got_n), 32'd6);
    chk("bp_no_bubble", 32'(last_cyc - first_cyc), 32'd5);
    chk("bp_idle_busy", 32'(busy), 32'd0);

    // streaming: 16 back-to-back ops
    exp_q.delete();
    got_n = 0;
    first_cyc = -1;
    last_cyc = -1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          @(negedge clock);
          cmd_src_a   = 32'(i);
          cmd_src_b   = 32'd100;
          cmd_op_code = ADD;
          cmd_valid   = 1'b1;
          chk("st_cmd_ready", 32'(cmd_ready), 32'd1);
          exp_q.push_back(32'(i + 100));
          @(posedge clock);
        end
        #1 cmd_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 40; c++) begin
          @(negedge clock);
          if (rsp_valid) begin
            if (first_cyc < 0) first_cyc = c;
            last_cyc = c;
            if (exp_q.size() > 0) chk("st_order", rsp_result, exp_q.pop_front());
            got_n++;
          end
        end
      end
    join
    chk("st_count", 32'(got_n), 32'd16);
    chk("st_no_bubble", 32'(last_cyc - first_cyc), 32'd15);

    // reset mid-flight with stalled pipeline
    @(negedge clock);
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      cmd_src_a   = 32'(i + 1);
      cmd_src_b   = 32'd1;
      cmd_op_code = ADD;
      cmd_valid   = 1'b1;
      @(posedge clock);
    end
    #1 cmd_valid = 1'b0;
    @(negedge clock);
    chk("mr_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clock);
    chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mr_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mr_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    got_n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (rsp_valid) got_n++;
    end
    chk("mr_no_stale", 32'(got_n), 32'd0);

    run_vec(vecs[0]);
    run_vec(vecs[1]);
    run_vec(vecs[7]);
`ifdef ALU_DRV_STATS_EN
    chk("stats_ops_done", 32'(ops_done), 32'd3);
    chk("stats_zero_cnt", 32'(zero_cnt), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
